swizzle_load_sequencer: RTL and testbench

Sequences whole DRAM-to-CRAM load jobs through the swizzle_dram_to_cram block. It accepts one job descriptor, issues a series of fixed-length read bursts to the memory controller, and forwards the returned words, registered, to the swizzle. It holds the swizzle's CRAM start address stable for each burst and advances it by a stride per burst. Between bursts it waits for the swizzle to flush. It sits between the DRAM read port and the swizzle instance inside the CoMeFa load path.

---
 rtl/swizzle_pkg.sv | 33 +++
 rtl/swizzle_load_sequencer_if.sv | 45 ++++
 rtl/swz_beat_reg.sv | 62 ++++++
 rtl/swizzle_load_sequencer.sv | 145 ++++++++++++++
 tb/tb_swizzle_load_sequencer.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/swizzle_pkg.sv
// Shared constants, FSM state encoding and descriptor helpers for the
// swizzle DRAM-to-CRAM load path.
package swizzle_pkg;

  localparam int MEM_CTRL_DWIDTH         = 40;
  localparam int RAM_PORT_AWIDTH         = 9;
  localparam int LOG_NUM_CRAMS           = 4;
  localparam int RAM_ADDR_WIDTH          = RAM_PORT_AWIDTH + LOG_NUM_CRAMS;
  localparam int COUNT_TO_SWITCH_BUFFERS = 40;
  localparam int BURST_LEN               = 2 * COUNT_TO_SWITCH_BUFFERS;
  localparam int DRAM_AWIDTH             = 32;
  localparam int LOG_MAX_BURSTS          = 8;
  localparam int BEAT_CNT_WIDTH          = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    STREAM = 2'd2,
    FLUSH  = 2'd3
  } seq_state_e;

  // A zero burst count still moves one burst.
  function automatic logic [LOG_MAX_BURSTS-1:0] burst_count(input logic [LOG_MAX_BURSTS-1:0] n);
    logic [LOG_MAX_BURSTS-1:0] r;
    if (n == {LOG_MAX_BURSTS{1'b0}}) begin
      r = LOG_MAX_BURSTS'(1);
    end else begin
      r = n;
    end
    return r;
  endfunction

endpackage

// File: rtl/swizzle_load_sequencer_if.sv
// Job command, DRAM request/read and swizzle-facing signals of the load sequencer.
interface swizzle_load_sequencer_if;
  import swizzle_pkg::*;

  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [DRAM_AWIDTH-1:0]    cmd_dram_base;
  logic [RAM_ADDR_WIDTH-1:0] cmd_cram_start;
  logic [RAM_ADDR_WIDTH-1:0] cmd_cram_stride;
  logic [LOG_MAX_BURSTS-1:0] cmd_num_bursts;

  logic                       dram_req_valid;
  logic                       dram_req_ready;
  logic [DRAM_AWIDTH-1:0]     dram_req_addr;
  logic                       dram_rd_valid;
  logic [MEM_CTRL_DWIDTH-1:0] dram_rd_data;
  logic                       dram_rd_last;

  logic                       swz_data_valid;
  logic [MEM_CTRL_DWIDTH-1:0] swz_data;
  logic                       swz_data_last;
  logic [RAM_ADDR_WIDTH-1:0]  swz_ram_start_addr;
  logic                       swz_ready;

  logic busy;
  logic done;
  logic err;

  modport master (
    input  cmd_valid, cmd_dram_base, cmd_cram_start, cmd_cram_stride, cmd_num_bursts,
    input  dram_req_ready, dram_rd_valid, dram_rd_data, dram_rd_last, swz_ready,
    output cmd_ready, dram_req_valid, dram_req_addr,
    output swz_data_valid, swz_data, swz_data_last, swz_ram_start_addr,
    output busy, done, err
  );

  modport slave (
    output cmd_valid, cmd_dram_base, cmd_cram_start, cmd_cram_stride, cmd_num_bursts,
    output dram_req_ready, dram_rd_valid, dram_rd_data, dram_rd_last, swz_ready,
    input  cmd_ready, dram_req_valid, dram_req_addr,
    input  swz_data_valid, swz_data, swz_data_last, swz_ram_start_addr,
    input  busy, done, err
  );

endinterface

// File: rtl/swz_beat_reg.sv
// One-cycle output register for DRAM read beats, with per-burst beat counter
// and burst-length check that terminates a burst early or late.
module swz_beat_reg
  import swizzle_pkg::*;
#(
  parameter int BURST_LEN = swizzle_pkg::BURST_LEN
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       clr_cnt_s,
  input  logic                       in_stream_s,
  input  logic                       rd_valid,
  input  logic [MEM_CTRL_DWIDTH-1:0] rd_data,
  input  logic                       rd_last,
  output logic                       data_valid_r,
  output logic [MEM_CTRL_DWIDTH-1:0] data_r,
  output logic                       data_last_r,
  output logic                       burst_end_s,
  output logic                       len_err_s
);

  localparam logic [BEAT_CNT_WIDTH-1:0] LAST_IDX = BEAT_CNT_WIDTH'(BURST_LEN - 1);

  logic                      accept_s;
  logic                      at_max_s;
  logic [BEAT_CNT_WIDTH-1:0] beat_cnt_r;

  // Classify the current beat: a burst ends on last or on the final index, and mismatch is an error.
  always_comb begin
    accept_s = in_stream_s & rd_valid;
    at_max_s = (beat_cnt_r == LAST_IDX);
    if (accept_s) begin
      burst_end_s = rd_last | at_max_s;
      len_err_s   = rd_last ^ at_max_s;
    end else begin
      burst_end_s = 1'b0;
      len_err_s   = 1'b0;
    end
  end

  // Output register and beat counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_valid_r <= 1'b0;
      data_r       <= {MEM_CTRL_DWIDTH{1'b0}};
      data_last_r  <= 1'b0;
      beat_cnt_r   <= {BEAT_CNT_WIDTH{1'b0}};
    end else begin
      data_valid_r <= accept_s;
      data_last_r  <= burst_end_s;
      if (accept_s) begin
        data_r <= rd_data;
      end
      if (clr_cnt_s) begin
        beat_cnt_r <= {BEAT_CNT_WIDTH{1'b0}};
      end else if (accept_s) begin
        beat_cnt_r <= beat_cnt_r + BEAT_CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/swizzle_load_sequencer.sv
// Splits a DRAM-to-CRAM load job into fixed-length bursts, forwards read beats
// to the swizzle and steps the CRAM start address between flushed bursts.
module swizzle_load_sequencer
  import swizzle_pkg::*;
#(
  parameter int BURST_LEN = swizzle_pkg::BURST_LEN
) (
  input logic                      clk,
  input logic                      resetn,
  swizzle_load_sequencer_if.master bus
);

  seq_state_e                state_r;
  seq_state_e                state_nxt_s;
  logic                      flush_first_r;
  logic                      clr_cnt_s;
  logic                      advance_s;
  logic                      last_burst_s;
  logic                      stray_beat_s;
  logic                      burst_end_s;
  logic                      len_err_s;
  logic                      cmd_ready_r;
  logic                      busy_r;
  logic                      done_r;
  logic                      err_r;
  logic                      dram_req_valid_r;
  logic [DRAM_AWIDTH-1:0]    addr_r;
  logic [RAM_ADDR_WIDTH-1:0] cram_r;
  logic [RAM_ADDR_WIDTH-1:0] stride_r;
  logic [LOG_MAX_BURSTS-1:0] bursts_left_r;

  swz_beat_reg #(.BURST_LEN(BURST_LEN)) u_beat_reg (
    .clk          (clk),
    .resetn       (resetn),
    .clr_cnt_s    (clr_cnt_s),
    .in_stream_s  (state_r == STREAM),
    .rd_valid     (bus.dram_rd_valid),
    .rd_data      (bus.dram_rd_data),
    .rd_last      (bus.dram_rd_last),
    .data_valid_r (bus.swz_data_valid),
    .data_r       (bus.swz_data),
    .data_last_r  (bus.swz_data_last),
    .burst_end_s  (burst_end_s),
    .len_err_s    (len_err_s)
  );

  // Next-state decode; a FLUSH exit is blocked during its first cycle while the swizzle sees the last beat.
  always_comb begin
    state_nxt_s  = state_r;
    clr_cnt_s    = 1'b0;
    advance_s    = 1'b0;
    last_burst_s = (bursts_left_r == LOG_MAX_BURSTS'(1));
    stray_beat_s = bus.dram_rd_valid & (state_r != STREAM);
    case (state_r)
      IDLE: begin
        if (bus.cmd_valid) begin
          state_nxt_s = REQ;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      REQ: begin
        if (bus.dram_req_ready) begin
          state_nxt_s = STREAM;
          clr_cnt_s   = 1'b1;
        end else begin
          state_nxt_s = REQ;
        end
      end
      STREAM: begin
        if (burst_end_s) begin
          state_nxt_s = FLUSH;
        end else begin
          state_nxt_s = STREAM;
        end
      end
      FLUSH: begin
        if (!flush_first_r && bus.swz_ready) begin
          advance_s = 1'b1;
          if (last_burst_s) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = REQ;
          end
        end else begin
          state_nxt_s = FLUSH;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Registered status outputs, descriptor/address tracking and sticky error.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      flush_first_r    <= 1'b0;
      cmd_ready_r      <= 1'b1;
      busy_r           <= 1'b0;
      done_r           <= 1'b0;
      err_r            <= 1'b0;
      dram_req_valid_r <= 1'b0;
      addr_r           <= {DRAM_AWIDTH{1'b0}};
      cram_r           <= {RAM_ADDR_WIDTH{1'b0}};
      stride_r         <= {RAM_ADDR_WIDTH{1'b0}};
      bursts_left_r    <= {LOG_MAX_BURSTS{1'b0}};
    end else begin
      flush_first_r    <= (state_r == STREAM);
      cmd_ready_r      <= (state_nxt_s == IDLE);
      busy_r           <= (state_nxt_s != IDLE);
      dram_req_valid_r <= (state_nxt_s == REQ);
      done_r           <= advance_s & last_burst_s;
      if (state_r == IDLE && bus.cmd_valid) begin
        addr_r        <= bus.cmd_dram_base;
        cram_r        <= bus.cmd_cram_start;
        stride_r      <= bus.cmd_cram_stride;
        bursts_left_r <= burst_count(bus.cmd_num_bursts);
      end else if (advance_s) begin
        addr_r        <= addr_r + DRAM_AWIDTH'(BURST_LEN);
        cram_r        <= cram_r + stride_r;
        bursts_left_r <= bursts_left_r - LOG_MAX_BURSTS'(1);
      end
      if (len_err_s || stray_beat_s) begin
        err_r <= 1'b1;
      end
    end
  end

  assign bus.cmd_ready          = cmd_ready_r;
  assign bus.busy               = busy_r;
  assign bus.done               = done_r;
  assign bus.err                = err_r;
  assign bus.dram_req_valid     = dram_req_valid_r;
  assign bus.dram_req_addr      = addr_r;
  assign bus.swz_ram_start_addr = cram_r;

endmodule

// File: tb/tb_swizzle_load_sequencer.sv
// Directed bench for swizzle_load_sequencer: single and multi-burst jobs,
// request back-pressure, beat gaps, length errors and mid-job reset.
module tb_swizzle_load_sequencer;
  import swizzle_pkg::*;

  logic clk = 1'b0;
  logic resetn;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   burst_id = 1;

  swizzle_load_sequencer_if bus();

  swizzle_load_sequencer dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chkw(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [MEM_CTRL_DWIDTH-1:0] beat_data(input int id, input int i);
    return {8'(id), 32'(i)};
  endfunction

  task automatic chk_reset(input string tag);
    chk1({tag, "_cmd_ready"}, bus.cmd_ready, 1'b1);
    chk1({tag, "_req_valid"}, bus.dram_req_valid, 1'b0);
    chk1({tag, "_swz_valid"}, bus.swz_data_valid, 1'b0);
    chk1({tag, "_swz_last"}, bus.swz_data_last, 1'b0);
    chkw({tag, "_swz_data"}, 64'(bus.swz_data), 64'h0);
    chkw({tag, "_swz_cram"}, 64'(bus.swz_ram_start_addr), 64'h0);
    chkw({tag, "_req_addr"}, 64'(bus.dram_req_addr), 64'h0);
    chk1({tag, "_busy"}, bus.busy, 1'b0);
    chk1({tag, "_done"}, bus.done, 1'b0);
    chk1({tag, "_err"}, bus.err, 1'b0);
  endtask

  task automatic send_cmd(input logic [31:0] base, input logic [12:0] start,
                          input logic [12:0] stride, input logic [7:0] num);
    chk1("cmd_ready_idle", bus.cmd_ready, 1'b1);
    bus.cmd_dram_base   = base;
    bus.cmd_cram_start  = start;
    bus.cmd_cram_stride = stride;
    bus.cmd_num_bursts  = num;
    bus.cmd_valid       = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    chk1("cmd_ready_busy", bus.cmd_ready, 1'b0);
    chk1("busy_after_cmd", bus.busy, 1'b1);
    chkw("cram_after_cmd", 64'(bus.swz_ram_start_addr), 64'(start));
  endtask

  task automatic req_phase(input logic [31:0] exp_addr, input int delay);
    chk1("req_valid", bus.dram_req_valid, 1'b1);
    chkw("req_addr", 64'(bus.dram_req_addr), 64'(exp_addr));
    for (int k = 0; k < delay; k++) begin
      tick();
      chk1("req_valid_hold", bus.dram_req_valid, 1'b1);
      chkw("req_addr_hold", 64'(bus.dram_req_addr), 64'(exp_addr));
    end
    bus.dram_req_ready = 1'b1;
    tick();
    bus.dram_req_ready = 1'b0;
    chk1("req_drop", bus.dram_req_valid, 1'b0);
  endtask

  task automatic stream(input int nbeats, input int gap, input int last_at, input logic [12:0] exp_cram);
    logic [MEM_CTRL_DWIDTH-1:0] d;
    for (int i = 1; i <= nbeats; i++) begin
      d = beat_data(burst_id, i);
      bus.dram_rd_valid = 1'b1;
      bus.dram_rd_data  = d;
      bus.dram_rd_last  = (i == last_at);
      tick();
      bus.dram_rd_valid = 1'b0;
      bus.dram_rd_last  = 1'b0;
      chk1("swz_valid", bus.swz_data_valid, 1'b1);
      chkw("swz_data", 64'(bus.swz_data), 64'(d));
      chk1("swz_last", bus.swz_data_last, (i == last_at) || (i == BURST_LEN));
      chkw("swz_cram", 64'(bus.swz_ram_start_addr), 64'(exp_cram));
      if (gap > 0 && (i % gap) == 0 && i < nbeats) begin
        tick();
        chk1("swz_gap", bus.swz_data_valid, 1'b0);
      end
    end
    burst_id++;
  endtask

  task automatic flush_phase(input int wait_cycles, input logic final_burst);
    bus.cmd_valid     = 1'b1;
    bus.cmd_dram_base = 32'hDEAD_0000;
    for (int k = 0; k < wait_cycles; k++) begin
      tick();
      chk1("flush_no_req", bus.dram_req_valid, 1'b0);
      chk1("flush_no_done", bus.done, 1'b0);
      chk1("flush_busy", bus.busy, 1'b1);
      chk1("flush_cmd_ready", bus.cmd_ready, 1'b0);
    end
    bus.cmd_valid = 1'b0;
    bus.swz_ready = 1'b1;
    if (wait_cycles == 0) begin
      tick();
      chk1("flush_mask_req", bus.dram_req_valid, 1'b0);
      chk1("flush_mask_done", bus.done, 1'b0);
    end
    tick();
    bus.swz_ready = 1'b0;
    if (final_burst) begin
      chk1("done_pulse", bus.done, 1'b1);
      chk1("done_idle_busy", bus.busy, 1'b0);
      chk1("done_cmd_ready", bus.cmd_ready, 1'b1);
      chk1("done_no_req", bus.dram_req_valid, 1'b0);
      tick();
      chk1("done_clear", bus.done, 1'b0);
    end else begin
      chk1("next_req", bus.dram_req_valid, 1'b1);
      chk1("next_no_done", bus.done, 1'b0);
    end
  endtask

  task automatic do_burst(input logic [31:0] addr, input logic [12:0] cram, input int delay,
                          input int gap, input int nbeats, input int last_at,
                          input int wait_cycles, input logic final_burst);
    req_phase(addr, delay);
    stream(nbeats, gap, last_at, cram);
    flush_phase(wait_cycles, final_burst);
  endtask

  initial begin
    resetn              = 1'b0;
    bus.cmd_valid       = 1'b0;
    bus.cmd_dram_base   = 32'h0;
    bus.cmd_cram_start  = 13'h0;
    bus.cmd_cram_stride = 13'h0;
    bus.cmd_num_bursts  = 8'h0;
    bus.dram_req_ready  = 1'b0;
    bus.dram_rd_valid   = 1'b0;
    bus.dram_rd_data    = 40'h0;
    bus.dram_rd_last    = 1'b0;
    bus.swz_ready       = 1'b0;
    #12;
    chk_reset("por");
    @(posedge clk);
    #1;
    resetn = 1'b1;
    tick();
    chk_reset("idle");

    // Single burst, back-to-back beats.
    send_cmd(32'h100, 13'h020, 13'h000, 8'd1);
    do_burst(32'h100, 13'h020, 0, 0, 80, 80, 3, 1'b1);
    chk1("err_single", bus.err, 1'b0);

    // Three bursts: back-pressured request, gapped data, masked first flush cycle.
    send_cmd(32'h100, 13'h020, 13'h004, 8'd3);
    do_burst(32'h100, 13'h020, 5, 0, 80, 80, 3, 1'b0);
    do_burst(32'h150, 13'h024, 0, 3, 80, 80, 2, 1'b0);
    do_burst(32'h1A0, 13'h028, 0, 0, 80, 80, 0, 1'b1);
    chk1("err_multi", bus.err, 1'b0);

    // Zero burst count runs one burst.
    send_cmd(32'h3000, 13'h100, 13'h010, 8'd0);
    do_burst(32'h3000, 13'h100, 0, 0, 80, 80, 1, 1'b1);

    // CRAM address wraps silently.
    send_cmd(32'h2000, 13'h1FFE, 13'h0004, 8'd2);
    do_burst(32'h2000, 13'h1FFE, 0, 0, 80, 80, 2, 1'b0);
    do_burst(32'h2050, 13'h0002, 0, 0, 80, 80, 2, 1'b1);
    chk1("err_wrap", bus.err, 1'b0);

    // Early last on beat 50: err sticks, job continues.
    send_cmd(32'h400, 13'h040, 13'h008, 8'd2);
    do_burst(32'h400, 13'h040, 0, 0, 50, 50, 2, 1'b0);
    chk1("err_early_last", bus.err, 1'b1);
    do_burst(32'h450, 13'h048, 0, 0, 80, 80, 2, 1'b1);
    chk1("err_sticky", bus.err, 1'b1);

    // Asynchronous reset during beat 30 of burst 2.
    send_cmd(32'h800, 13'h010, 13'h001, 8'd3);
    do_burst(32'h800, 13'h010, 0, 0, 80, 80, 2, 1'b0);
    req_phase(32'h850, 0);
    stream(29, 0, 0, 13'h011);
    bus.dram_rd_valid = 1'b1;
    bus.dram_rd_data  = beat_data(burst_id, 30);
    #2;
    resetn = 1'b0;
    #1;
    chk_reset("mid_rst");
    bus.dram_rd_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    tick();
    chk_reset("post_rst");

    // Missing last: forced on beat 80 with err.
    send_cmd(32'h900, 13'h030, 13'h000, 8'd1);
    do_burst(32'h900, 13'h030, 0, 0, 80, 0, 2, 1'b1);
    chk1("err_no_last", bus.err, 1'b1);

    // Stray beat in IDLE is dropped and flagged.
    resetn = 1'b0;
    #1;
    chk1("rst2_err", bus.err, 1'b0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    bus.dram_rd_valid = 1'b1;
    bus.dram_rd_data  = 40'hAB_CDEF_0123;
    tick();
    bus.dram_rd_valid = 1'b0;
    chk1("stray_dropped", bus.swz_data_valid, 1'b0);
    chk1("stray_err", bus.err, 1'b1);
    chk1("stray_idle", bus.cmd_ready, 1'b1);
    tick();
    chk1("stray_err_hold", bus.err, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
